// File: rtl/imem_loadable.sv
// imem_loadable: run-time loadable instruction memory (DEPTH x IW) with registered fetch.
// Latency: fetch_req at edge N -> inst/inst_valid at N+1; back-to-back fetches give 1 word/cycle.
// Backpressure: ld_ready is high only in LOAD; ld_data is written on ld_valid && ld_ready.
// Ports: clk, rst_n (async active-low); fetch side pc/fetch_req -> inst/inst_valid;
//   load side ld_start/ld_base/ld_len, ld_valid/ld_data -> ld_ready, ld_done; status running, fetch_fault.
// Optional macro IMEM_FAULT_EN: builds the sticky fetch_fault flag (otherwise tied 0).
module imem_loadable #(
  parameter int            IW    = 9,
  parameter int            AW    = 8,
  parameter int            DEPTH = 256,
  parameter logic [IW-1:0] FILL  = {IW{1'b1}}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc,
  input  logic          fetch_req,
  output logic [IW-1:0] inst,
  output logic          inst_valid,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_len,
  input  logic          ld_valid,
  input  logic [IW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic          running,
  output logic          fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  // Depth at one bit wider than the address so DEPTH == 2**AW is representable.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_nx;
  logic [AW-1:0] wptr;
  logic [AW:0]   remain;
  logic [IW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;

  logic          ld_hs;
  logic          last_hs;
  logic          start_acc;
  logic          len_zero;
  logic [AW:0]   len_clamped;
  logic [AW:0]   base_mod;
  logic [AW-1:0] wptr_inc;
  logic          fetch_hit;

  assign ld_hs     = ld_valid && ld_ready;
  assign last_hs   = ld_hs && (remain == (AW+1)'(1));
  // ld_start is only honoured outside LOAD; a start during a load is dropped.
  assign start_acc = ld_start && (state != S_LOAD);
  assign len_zero  = (ld_len == '0);

  assign len_clamped = (ld_len > DEPTH_W) ? DEPTH_W : ld_len;
  assign base_mod    = {1'b0, ld_base} % DEPTH_W;
  assign wptr_inc    = ({1'b0, wptr} == DEPTH_W - (AW+1)'(1)) ? '0 : wptr + 1'b1;

  // Only RUN serves stored code; a fetch in IDLE or LOAD sees FILL.
  assign fetch_hit = (state == S_RUN) && ({1'b0, pc} < DEPTH_W) && written[pc];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_RUN: if (ld_start) state_nx = len_zero ? S_RUN : S_LOAD;
      S_LOAD:        if (last_hs)  state_nx = S_RUN;
      default:       state_nx = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ld_ready = 1'b0;
    running  = 1'b0;
    case (state)
      S_LOAD:  ld_ready = 1'b1;
      S_RUN:   running  = 1'b1;
      default: ;
    endcase
  end

  // ---------------- load pointer, written bits, pulses, fetch port ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      remain     <= '0;
      written    <= '0;
      ld_done    <= 1'b0;
      inst       <= FILL;
      inst_valid <= 1'b0;
    end else begin
      if (start_acc) begin
        wptr   <= base_mod[AW-1:0];
        remain <= len_clamped;
      end else if (ld_hs) begin
        written[wptr] <= 1'b1;
        wptr          <= wptr_inc;
        remain        <= remain - (AW+1)'(1);
      end
      // Zero-length load completes immediately, so it also pulses ld_done.
      ld_done    <= (start_acc && len_zero) || last_hs;
      inst_valid <= fetch_req;
      if (fetch_req) inst <= fetch_hit ? mem[pc] : FILL;
    end
  end

  // Storage array is not reset; the written bits mask stale contents.
  always_ff @(posedge clk) begin
    if (ld_hs) mem[wptr] <= ld_data;
  end

`ifdef IMEM_FAULT_EN
  logic fault_q;
  // A RUN-state miss sets the flag; if it coincides with an accepted reload the
  // set wins so that fault is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       fault_q <= 1'b0;
    else if (fetch_req && state == S_RUN && !fetch_hit) fault_q <= 1'b1;
    else if (start_acc)                               fault_q <= 1'b0;
  end
  assign fetch_fault = fault_q;
`else
  assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// tb_imem_loadable: table vectors plus randomized loads/fetches against an array model.
module tb_imem_loadable;
  localparam int          DEPTH = 256;
  localparam logic [8:0]  FILL  = 9'h1FF;
`ifdef IMEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] pc;
  logic       fetch_req;
  logic [8:0] inst;
  logic       inst_valid;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [8:0] ld_len;
  logic       ld_valid;
  logic [8:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       running;
  logic       fetch_fault;

  imem_loadable #(.IW(9), .AW(8), .DEPTH(DEPTH), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .fetch_req(fetch_req),
    .inst(inst), .inst_valid(inst_valid),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .running(running), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: what each address holds, whether it was loaded, and the flags.
  logic [8:0] m_mem [DEPTH];
  bit         m_wr  [DEPTH];
  bit         m_run;
  bit         m_fault;
  logic [8:0] m_last;
  logic [8:0] ld_q [$];

  typedef struct {
    int         addr;
    logic [8:0] exp;
  } vec_t;
  vec_t basic_tab [4];
  vec_t wrap_tab  [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] m_fetch(input int p);
    if (m_run && p < DEPTH && m_wr[p]) return m_mem[p];
    return FILL;
  endfunction

  function automatic bit m_miss(input int p);
    return m_run && !(p < DEPTH && m_wr[p]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch_exp(input int p, input logic [8:0] exp, input string nm);
    bit miss;
    miss = m_miss(p);
    pc = p[7:0];
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    if (FAULT_EN && miss) m_fault = 1'b1;
    m_last = exp;
    chk({nm, "_vld"},   32'(inst_valid),  32'd1);
    chk(nm,             32'(inst),        32'(exp));
    chk({nm, "_fault"}, 32'(fetch_fault), 32'(m_fault));
  endtask

  task automatic do_idle();
    fetch_req = 1'b0;
    tick();
    chk("idle_vld",  32'(inst_valid), 32'd0);
    chk("idle_hold", 32'(inst),       32'(m_last));
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; fetch_req = 1'b0;
    #2;
    chk({nm, "_inst"},  32'(inst),        32'(FILL));
    chk({nm, "_ivld"},  32'(inst_valid),  32'd0);
    chk({nm, "_ready"}, 32'(ld_ready),    32'd0);
    chk({nm, "_done"},  32'(ld_done),     32'd0);
    chk({nm, "_run"},   32'(running),     32'd0);
    chk({nm, "_fault"}, 32'(fetch_fault), 32'd0);
    for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
    m_run = 1'b0; m_fault = 1'b0; m_last = FILL;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  // mode 0: ld_valid always high; 1: alternate 1,0,1,...; 2: random gaps.
  // side=1 adds random fetches, ignored ld_starts during the stream, and a
  // fetch coinciding with the starting ld_start when already running.
  task automatic do_load(input int base, input int len, input int mode, input bit side);
    bit         co_fetch, co_miss, v, f, js;
    int         cp, n, idx, cyc, bad_ready, early_done;
    logic [8:0] co_exp;
    co_fetch = side && m_run && ($urandom_range(0, 1) == 1);
    cp       = $urandom_range(0, 255);
    co_exp   = m_fetch(cp);
    co_miss  = m_miss(cp);
    ld_start = 1'b1; ld_base = base[7:0]; ld_len = len[8:0];
    fetch_req = co_fetch; pc = cp[7:0];
    tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    m_fault = 1'b0;
    if (FAULT_EN && co_fetch && co_miss) m_fault = 1'b1;
    if (co_fetch) begin
      m_last = co_exp;
      chk("start_fetch_vld", 32'(inst_valid), 32'd1);
      chk("start_fetch",     32'(inst),       32'(co_exp));
    end
    chk("start_fault", 32'(fetch_fault), 32'(m_fault));
    n = (len > DEPTH) ? DEPTH : len;
    if (n == 0) begin
      m_run = 1'b1;
      chk("zero_done",  32'(ld_done),  32'd1);
      chk("zero_run",   32'(running),  32'd1);
      chk("zero_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("zero_done_pulse", 32'(ld_done), 32'd0);
      return;
    end
    m_run = 1'b0;
    chk("load_ready", 32'(ld_ready), 32'd1);
    chk("load_run",   32'(running),  32'd0);
    idx = 0; cyc = 0; bad_ready = 0; early_done = 0;
    while (idx < n && cyc < 4 * n + 8) begin
      v  = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 3) != 0);
      f  = side && ($urandom_range(0, 2) == 0);
      js = side && ($urandom_range(0, 9) == 0);
      if (ld_ready !== 1'b1) bad_ready++;
      if (ld_done !== 1'b0) early_done++;
      ld_valid = v; ld_data = ld_q[idx];
      fetch_req = f; pc = 8'($urandom_range(0, 255));
      ld_start = js; ld_base = 8'($urandom_range(0, 255)); ld_len = 9'($urandom_range(0, 300));
      tick();
      if (v) begin
        m_mem[(base + idx) % DEPTH] = ld_q[idx];
        m_wr[(base + idx) % DEPTH]  = 1'b1;
        idx++;
      end
      if (f) begin
        m_last = FILL;
        chk("load_fetch_vld", 32'(inst_valid), 32'd1);
        chk("load_fetch",     32'(inst),       32'(FILL));
      end
      cyc++;
    end
    ld_valid = 1'b0; fetch_req = 1'b0; ld_start = 1'b0;
    chk("load_words_sent", 32'(idx), 32'(n));
    chk("load_ready_held", 32'(bad_ready), 32'd0);
    chk("load_no_early_done", 32'(early_done), 32'd0);
    m_run = 1'b1;
    chk("load_done",  32'(ld_done),     32'd1);
    chk("load_ready_drop", 32'(ld_ready), 32'd0);
    chk("load_running", 32'(running),   32'd1);
    chk("load_fault", 32'(fetch_fault), 32'(m_fault));
    tick();
    chk("load_done_pulse", 32'(ld_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len, k;
    basic_tab = '{'{0, 9'h106}, '{1, 9'h049}, '{2, 9'h069}, '{3, 9'h1FF}};
    wrap_tab  = '{'{254, 9'h1A1}, '{255, 9'h1A2}, '{0, 9'h1A3}, '{1, 9'h1A4}, '{2, 9'h1FF}};

    rst_n = 1'b1; pc = '0; fetch_req = 1'b0; ld_start = 1'b0; ld_base = '0;
    ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    #3;
    do_reset("reset");

    // Fetch in IDLE returns FILL, no fault.
    do_fetch_exp(0, FILL, "idle_fetch");
    do_idle();

    // Basic load then back-to-back fetches.
    ld_q = '{9'h106, 9'h049, 9'h069};
    do_load(0, 3, 0, 1'b0);
    foreach (basic_tab[i]) do_fetch_exp(basic_tab[i].addr, basic_tab[i].exp, "basic_fetch");
    do_idle();

    // Same load with ld_valid toggling 1,0,1,0,1.
    do_load(0, 3, 1, 1'b0);
    foreach (basic_tab[i]) do_fetch_exp(basic_tab[i].addr, basic_tab[i].exp, "bp_fetch");

    // Wrap-around from a clean memory.
    do_reset("reset2");
    ld_q = '{9'h1A1, 9'h1A2, 9'h1A3, 9'h1A4};
    do_load(254, 4, 0, 1'b0);
    foreach (wrap_tab[i]) do_fetch_exp(wrap_tab[i].addr, wrap_tab[i].exp, "wrap_fetch");

    // Fault flag: only 0..1 loaded, fetch 5 misses; flag sticky until next ld_start.
    do_reset("reset3");
    ld_q = '{9'h011, 9'h022};
    do_load(0, 2, 0, 1'b0);
    do_fetch_exp(5, FILL, "fault_fetch");
    for (int i = 0; i < 10; i++) do_idle();
    chk("fault_sticky", 32'(fetch_fault), 32'(FAULT_EN));
    ld_q = '{9'h033};
    do_load(7, 1, 0, 1'b0);
    chk("fault_cleared", 32'(fetch_fault), 32'd0);
    do_fetch_exp(7, 9'h033, "after_clear_fetch");

    // Reset mid-load, with a fetch during LOAD first.
    do_reset("reset4");
    ld_start = 1'b1; ld_base = 8'd0; ld_len = 9'd4;
    tick();
    ld_start = 1'b0;
    do_fetch_exp(0, FILL, "loadstate_fetch");
    ld_valid = 1'b1; ld_data = 9'h0AA;
    tick();
    ld_data = 9'h0BB;
    tick();
    ld_valid = 1'b0;
    do_reset("midload_reset");
    do_load(0, 0, 0, 1'b0);
    do_fetch_exp(0, FILL, "post_reset_fetch");

    // Randomized loads and fetches against the model.
    base = 0;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        base = $urandom_range(0, 255);
        len  = ($urandom_range(0, 9) == 0) ? $urandom_range(256, 300) : $urandom_range(0, 12);
        ld_q.delete();
        for (int j = 0; j < 300; j++) ld_q.push_back(9'($urandom_range(0, 511)));
        do_load(base, len, 2, 1'b1);
      end else begin
        k = $urandom_range(1, 6);
        for (int j = 0; j < k; j++) begin
          int p;
          p = (base + $urandom_range(0, 15)) % DEPTH;
          do_fetch_exp(p, m_fetch(p), "rand_fetch");
        end
        if ($urandom_range(0, 1) == 1) do_idle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
